// File: rtl/proton_targeting_ctrl_if.sv
// Sensor/fire bus between the torpedo sensor front end and proton_targeting_ctrl.
// master drives the sensor code, slave is the targeting controller.
interface proton_targeting_ctrl_if #(
    parameter int SENSOR_W = 3
);
    logic [SENSOR_W-1:0] sensor_in;
    logic                proton_fire;
    logic [2:0]          state_o;
    logic [3:0]          hit_count_o;
    logic [7:0]          shots_fired;

    modport master (
        output sensor_in,
        input  proton_fire, state_o, hit_count_o, shots_fired
    );

    modport slave (
        input  sensor_in,
        output proton_fire, state_o, hit_count_o, shots_fired
    );
endinterface

// File: rtl/proton_targeting_ctrl.sv
// Torpedo targeting FSM: calibrate, left/centre lock, timed hit window, registered fire pulse.
// Optional post-fire cooldown state enabled by defining PROTON_COOLDOWN_EN.
module proton_targeting_ctrl #(
    parameter int                  SENSOR_W        = 3,
    parameter logic [SENSOR_W-1:0] ONES_CODE       = '1,
    parameter logic [SENSOR_W-1:0] ABORT_CODE      = SENSOR_W'(3'b101),
    parameter logic [SENSOR_W-1:0] LEFT_CODE       = SENSOR_W'(3'b001),
    parameter logic [SENSOR_W-1:0] CENTER_CODE     = SENSOR_W'(3'b010),
    parameter logic [SENSOR_W-1:0] HIT_CODE        = SENSOR_W'(3'b100),
    parameter int                  CALIB_CYCLES    = 2,
    parameter int                  LOCK_TIMEOUT    = 0,
    parameter int                  WINDOW_LEN      = 16,
    parameter int                  HITS_REQ        = 2,
    parameter int                  FIRE_PULSE      = 1,
    parameter int                  COOLDOWN_CYCLES = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    proton_targeting_ctrl_if.slave bus
);
    localparam int WIN_W  = $clog2(WINDOW_LEN + 1);
    localparam int LOCK_W = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam int FIRE_W = (FIRE_PULSE == 1) ? 1 : $clog2(FIRE_PULSE + 1);

    // Elaboration-time guards on the legal parameter ranges.
    if (SENSOR_W < 2)                        $error("SENSOR_W must be >= 2");
    if (CALIB_CYCLES < 1 || CALIB_CYCLES > 15) $error("CALIB_CYCLES out of range");
    if (HITS_REQ < 1 || HITS_REQ > 15)       $error("HITS_REQ out of range");
    if (WINDOW_LEN < 1 || FIRE_PULSE < 1)    $error("WINDOW_LEN/FIRE_PULSE must be >= 1");
    if (COOLDOWN_CYCLES < 1)                 $error("COOLDOWN_CYCLES must be >= 1");

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALIB  = 3'd1,
        S_WAIT   = 3'd2,
        S_ARM    = 3'd3,
        S_WINDOW = 3'd4,
        S_FIRE   = 3'd5,
        S_COOL   = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          calib_q, calib_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [3:0]          hits_q, hits_d;
    logic [FIRE_W-1:0]   fcnt_q, fcnt_d;
    logic                fire_q, fire_d;
    logic [7:0]          shots_q, shots_d;
    logic                to_idle;
`ifdef PROTON_COOLDOWN_EN
    localparam int COOL_W = (COOLDOWN_CYCLES == 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);
    logic [COOL_W-1:0]   cool_q, cool_d;
`endif

    always_comb begin
        state_d = state_q;
        calib_d = calib_q;
        lock_d  = lock_q;
        win_d   = win_q;
        hits_d  = hits_q;
        fcnt_d  = fcnt_q;
        to_idle = 1'b0;
`ifdef PROTON_COOLDOWN_EN
        cool_d  = cool_q;
`endif
        // Cooldown is deaf to the sensor bus, abort included.
        if (state_q != S_COOL && bus.sensor_in == ABORT_CODE) begin
            to_idle = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (bus.sensor_in == ONES_CODE) begin
                    state_d = S_CALIB;
                    calib_d = 4'd1;
                end
                S_CALIB: begin
                    if (bus.sensor_in == ONES_CODE && calib_q < 4'(CALIB_CYCLES)) begin
                        calib_d = calib_q + 4'd1;
                    end else if (bus.sensor_in == LEFT_CODE && calib_q == 4'(CALIB_CYCLES)) begin
                        state_d = S_WAIT;
                        lock_d  = '0;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.sensor_in == CENTER_CODE) begin
                        state_d = S_ARM;
                    end else if (LOCK_TIMEOUT != 0) begin
                        lock_d = lock_q + 1'b1;
                        if (lock_d == LOCK_W'(LOCK_TIMEOUT)) to_idle = 1'b1;
                    end
                end
                S_ARM: begin
                    state_d = S_WINDOW;
                    win_d   = WIN_W'(1);
                    hits_d  = '0;
                end
                S_WINDOW: begin
                    if (bus.sensor_in == HIT_CODE) hits_d = hits_q + 4'd1;
                    // A qualifying hit wins even on the last window cycle.
                    if (bus.sensor_in == HIT_CODE && hits_d == 4'(HITS_REQ)) begin
                        state_d = S_FIRE;
                        fcnt_d  = FIRE_W'(1);
                    end else if (win_q == WIN_W'(WINDOW_LEN)) begin
                        to_idle = 1'b1;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
                S_FIRE: begin
                    if (fcnt_q == FIRE_W'(FIRE_PULSE)) begin
`ifdef PROTON_COOLDOWN_EN
                        state_d = S_COOL;
                        cool_d  = COOL_W'(1);
`else
                        to_idle = 1'b1;
`endif
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
`ifdef PROTON_COOLDOWN_EN
                S_COOL: begin
                    if (cool_q == COOL_W'(COOLDOWN_CYCLES)) to_idle = 1'b1;
                    else cool_d = cool_q + 1'b1;
                end
`endif
                default: to_idle = 1'b1;
            endcase
        end

        if (to_idle) begin
            state_d = S_IDLE;
            calib_d = '0;
            lock_d  = '0;
            win_d   = '0;
            hits_d  = '0;
            fcnt_d  = '0;
`ifdef PROTON_COOLDOWN_EN
            cool_d  = '0;
`endif
        end

        fire_d  = (state_d == S_FIRE);
        shots_d = shots_q;
        if (state_d == S_FIRE && state_q != S_FIRE && shots_q != 8'hFF) shots_d = shots_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            calib_q <= '0;
            lock_q  <= '0;
            win_q   <= '0;
            hits_q  <= '0;
            fcnt_q  <= '0;
            fire_q  <= 1'b0;
            shots_q <= '0;
`ifdef PROTON_COOLDOWN_EN
            cool_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            calib_q <= calib_d;
            lock_q  <= lock_d;
            win_q   <= win_d;
            hits_q  <= hits_d;
            fcnt_q  <= fcnt_d;
            fire_q  <= fire_d;
            shots_q <= shots_d;
`ifdef PROTON_COOLDOWN_EN
            cool_q  <= cool_d;
`endif
        end
    end

    assign bus.proton_fire = fire_q;
    assign bus.state_o     = state_q;
    assign bus.hit_count_o = hits_q;
    assign bus.shots_fired = shots_q;
endmodule
